// File: rtl/multicycle_ctrl.sv
// Moore control unit for the multicycle MIPS-subset datapath: sequences fetch,
// decode, execute, memory and writeback, and stalls on the shared-memory handshake.
//
// state  | meaning
// -------+------------------------------------------------
// FETCH  | read instruction, latch IR and advance PC on ready
// DECODE | read registers, precompute branch target
// MEMADR | compute lw/sw effective address
// MEMRD  | data read, held until mem_ready
// MEMWB  | write loaded word to rt
// MEMWR  | data write, held until mem_ready
// REXEC  | R-type ALU operation
// RWB    | write R-type result to rd
// BRANCH | beq compare, PC loads target when zero
// JUMP   | PC loads jump target
// ADDIEX | rs + sign-extended immediate
// ADDIWB | write addi result to rt
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_en,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  state_t state_q, state_d;

  logic       pc_write_c, pc_write_cond_c, i_or_d_c, mem_read_c, mem_write_c;
  logic       ir_write_c, reg_dst_c, mem_to_reg_c, reg_write_c, alu_src_a_c;
  logic       illegal_op_c;
  logic [1:0] alu_src_b_c, alu_op_c, pc_source_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_REXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_FETCH;
        endcase
      end
      // An opcode that is neither lw nor sw here abandons the access harmlessly.
      S_MEMADR: begin
        if (opcode == OP_LW)      state_d = S_MEMRD;
        else if (opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_FETCH;
      end
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_REXEC:  state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write_c      = 1'b0;
    pc_write_cond_c = 1'b0;
    i_or_d_c        = 1'b0;
    mem_read_c      = 1'b0;
    mem_write_c     = 1'b0;
    ir_write_c      = 1'b0;
    reg_dst_c       = 1'b0;
    mem_to_reg_c    = 1'b0;
    reg_write_c     = 1'b0;
    alu_src_a_c     = 1'b0;
    illegal_op_c    = 1'b0;
    alu_src_b_c     = 2'b00;
    alu_op_c        = 2'b00;
    pc_source_c     = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_read_c  = 1'b1;
        alu_src_b_c = 2'b01;
        ir_write_c  = mem_ready;
        pc_write_c  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b_c = 2'b11;
        illegal_op_c = !(opcode inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI});
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
      end
      S_MEMRD: begin
        mem_read_c = 1'b1;
        i_or_d_c   = 1'b1;
      end
      S_MEMWB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = 1'b1;
      end
      S_MEMWR: begin
        mem_write_c = 1'b1;
        i_or_d_c    = 1'b1;
      end
      S_REXEC: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = 2'b10;
      end
      S_RWB: begin
        reg_write_c = 1'b1;
        reg_dst_c   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_c     = 1'b1;
        alu_op_c        = 2'b01;
        pc_write_cond_c = 1'b1;
        pc_source_c     = 2'b01;
      end
      S_JUMP: begin
        pc_write_c  = 1'b1;
        pc_source_c = 2'b10;
      end
      S_ADDIWB: reg_write_c = 1'b1;
      default: ;
    endcase
  end

  // Reset gates every strobe so nothing (not even the FETCH read) reaches the datapath.
  assign pc_write      = reset_n & pc_write_c;
  assign pc_write_cond = reset_n & pc_write_cond_c;
  assign pc_en         = pc_write | (pc_write_cond & alu_zero);
  assign i_or_d        = reset_n & i_or_d_c;
  assign mem_read      = reset_n & mem_read_c;
  assign mem_write     = reset_n & mem_write_c;
  assign ir_write      = reset_n & ir_write_c;
  assign reg_dst       = reset_n & reg_dst_c;
  assign mem_to_reg    = reset_n & mem_to_reg_c;
  assign reg_write     = reset_n & reg_write_c;
  assign alu_src_a     = reset_n & alu_src_a_c;
  assign illegal_op    = reset_n & illegal_op_c;
  assign alu_src_b     = {2{reset_n}} & alu_src_b_c;
  assign alu_op        = {2{reset_n}} & alu_op_c;
  assign pc_source     = {2{reset_n}} & pc_source_c;
  assign state         = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class through its
// state sequence and compares state plus the packed strobe vector every cycle.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       alu_zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pc_write, pc_write_cond, pc_en, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD = 6'b111111;

  // Packing: {pcw,pcc,pce}_{iord,mrd,mwr,irw}_{rdst,m2r,rw,asa}_{asb}_{aop}_{psrc}_{ill}
  localparam logic [17:0] E_ZERO    = 18'b000_0000_0000_00_00_00_0;
  localparam logic [17:0] E_FETCH   = 18'b101_0101_0000_01_00_00_0;
  localparam logic [17:0] E_FETCH_W = 18'b000_0100_0000_01_00_00_0;
  localparam logic [17:0] E_DECODE  = 18'b000_0000_0000_11_00_00_0;
  localparam logic [17:0] E_DEC_ILL = 18'b000_0000_0000_11_00_00_1;
  localparam logic [17:0] E_MEMADR  = 18'b000_0000_0001_10_00_00_0;
  localparam logic [17:0] E_MEMRD   = 18'b000_1100_0000_00_00_00_0;
  localparam logic [17:0] E_MEMWB   = 18'b000_0000_0110_00_00_00_0;
  localparam logic [17:0] E_MEMWR   = 18'b000_1010_0000_00_00_00_0;
  localparam logic [17:0] E_REXEC   = 18'b000_0000_0001_00_10_00_0;
  localparam logic [17:0] E_RWB     = 18'b000_0000_1010_00_00_00_0;
  localparam logic [17:0] E_BR_T    = 18'b011_0000_0001_00_01_01_0;
  localparam logic [17:0] E_BR_N    = 18'b010_0000_0001_00_01_01_0;
  localparam logic [17:0] E_JUMP    = 18'b101_0000_0000_00_00_10_0;
  localparam logic [17:0] E_ADDIWB  = 18'b000_0000_0010_00_00_00_0;

  multicycle_ctrl dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_en(pc_en), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] outs();
    return {pc_write, pc_write_cond, pc_en, i_or_d, mem_read, mem_write, ir_write,
            reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
            illegal_op};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock, drive this cycle's inputs, then compare state and strobes.
  task automatic step(input string tag, input logic mr, input logic az,
                      input logic [5:0] op, input logic [3:0] exp_st,
                      input logic [17:0] exp_o);
    @(posedge clk);
    #1;
    mem_ready = mr;
    alu_zero  = az;
    opcode    = op;
    #1;
    check({tag, "_state"}, {28'd0, state}, {28'd0, exp_st});
    check({tag, "_outs"}, {14'd0, outs()}, {14'd0, exp_o});
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", {28'd0, state}, 32'd0);
    check("rst_outs", {14'd0, outs()}, {14'd0, E_ZERO});
    reset_n = 1'b1;
    #1;
    check("rel_state", {28'd0, state}, 32'd0);
    check("rel_outs", {14'd0, outs()}, {14'd0, E_FETCH});

    // lw, no stalls: 0,1,2,3,4,0
    step("lw_dec", 1, 0, OP_LW, 4'd1, E_DECODE);
    step("lw_adr", 1, 0, OP_LW, 4'd2, E_MEMADR);
    step("lw_rd",  1, 0, OP_LW, 4'd3, E_MEMRD);
    step("lw_wb",  1, 0, OP_LW, 4'd4, E_MEMWB);
    step("lw_f",   1, 0, OP_LW, 4'd0, E_FETCH);

    // sw with a two-cycle stall in MEMWR, then a one-cycle fetch stall
    step("sw_dec", 1, 0, OP_SW, 4'd1, E_DECODE);
    step("sw_adr", 1, 0, OP_SW, 4'd2, E_MEMADR);
    step("sw_wr0", 0, 0, OP_SW, 4'd5, E_MEMWR);
    step("sw_wr1", 0, 0, OP_SW, 4'd5, E_MEMWR);
    step("sw_wr2", 1, 0, OP_SW, 4'd5, E_MEMWR);
    step("fst_w",  0, 0, OP_SW, 4'd0, E_FETCH_W);
    step("fst_r",  1, 0, OP_SW, 4'd0, E_FETCH);

    // beq taken, then not taken; opcode churn in BRANCH is ignored
    step("bt_dec", 1, 0, OP_BEQ, 4'd1, E_DECODE);
    step("bt_br",  1, 1, OP_LW,  4'd8, E_BR_T);
    step("bt_f",   1, 0, OP_BEQ, 4'd0, E_FETCH);
    step("bn_dec", 1, 0, OP_BEQ, 4'd1, E_DECODE);
    step("bn_br",  1, 0, OP_BEQ, 4'd8, E_BR_N);
    step("bn_f",   1, 0, OP_J,   4'd0, E_FETCH);

    // j, R, addi back to back; opcode change during REXEC must not matter
    step("j_dec",  1, 0, OP_J,    4'd1,  E_DECODE);
    step("j_jmp",  1, 0, OP_J,    4'd9,  E_JUMP);
    step("j_f",    1, 0, OP_R,    4'd0,  E_FETCH);
    step("r_dec",  1, 0, OP_R,    4'd1,  E_DECODE);
    step("r_ex",   1, 0, OP_LW,   4'd6,  E_REXEC);
    step("r_wb",   1, 0, OP_LW,   4'd7,  E_RWB);
    step("r_f",    1, 0, OP_ADDI, 4'd0,  E_FETCH);
    step("ai_dec", 1, 0, OP_ADDI, 4'd1,  E_DECODE);
    step("ai_ex",  1, 0, OP_ADDI, 4'd10, E_MEMADR);
    step("ai_wb",  1, 0, OP_ADDI, 4'd11, E_ADDIWB);
    step("ai_f",   1, 0, OP_BAD,  4'd0,  E_FETCH);

    // illegal opcode pulses only in DECODE
    step("il_dec", 1, 0, OP_BAD, 4'd1, E_DEC_ILL);
    step("il_f",   1, 0, OP_LW,  4'd0, E_FETCH);

    // reset in a stalled MEMRD kills outputs immediately
    step("ra_dec", 1, 0, OP_LW, 4'd1, E_DECODE);
    step("ra_adr", 1, 0, OP_LW, 4'd2, E_MEMADR);
    step("ra_rd",  0, 0, OP_LW, 4'd3, E_MEMRD);
    #2;
    reset_n = 1'b0;
    #1;
    check("ra_state", {28'd0, state}, 32'd0);
    check("ra_outs", {14'd0, outs()}, {14'd0, E_ZERO});
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    check("ra_hold", {14'd0, outs()}, {14'd0, E_ZERO});
    reset_n = 1'b1;
    #1;
    check("ra_rel", {14'd0, outs()}, {14'd0, E_FETCH});
    step("ra_dec2", 1, 0, OP_J, 4'd1, E_DECODE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Moore-style control unit for the multicycle MIPS-subset datapath. Decodes the latched instruction opcode and sequences the register file, ALU, memory, IR and PC through fetch/decode/execute/memory/writeback states. Produces the combined PC enable, where the branch-taken term is pc_write_cond AND alu_zero, so the datapath needs no separate branch gate. Stalls on the memory handshake so one shared single-port memory serves instruction and data accesses.

## Interface
- No parameters; opcode encodings fixed: R=6'b000000, lw=6'b100011, sw=6'b101011, beq=6'b000100, j=6'b000010, addi=6'b001000.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- opcode  in  6  instruction bits [31:26] from IR
- alu_zero  in  1  ALU zero flag
- mem_ready  in  1  memory completed current read/write this cycle
- pc_write, pc_write_cond, pc_en  out  1  PC controls; pc_en = pc_write | (pc_write_cond & alu_zero)
- i_or_d, mem_read, mem_write, ir_write  out  1  memory/IR controls
- reg_dst, mem_to_reg, reg_write, alu_src_a  out  1  regfile/ALU muxes
- alu_src_b, alu_op, pc_source  out  2  ALU B mux, ALU op class (00 add, 01 sub, 10 funct), PC mux (00 ALU, 01 ALUOut, 10 jump)
- illegal_op  out  1  one-cycle pulse on undefined opcode
- state  out  4  current state, for debug

## Operation
- Encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11; 12-15 unreachable and return to FETCH.
- Outputs are pure decode of state, plus mem_ready and alu_zero where noted. Listed signals are asserted; all others are 0.
  - FETCH: mem_read, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write and pc_write only when mem_ready=1. Stays in FETCH while mem_ready=0.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Branches on opcode: lw/sw→MEMADR, R→REXEC, beq→BRANCH, j→JUMP, addi→ADDIEX, other→FETCH with illegal_op=1.
  - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEMRD for lw, MEMWR for sw.
  - MEMRD: mem_read, i_or_d=1. Goes to MEMWB when mem_ready=1, else holds.
  - MEMWB: reg_write, mem_to_reg=1, reg_dst=0. Goes to FETCH.
  - MEMWR: mem_write, i_or_d=1. Goes to FETCH when mem_ready=1, else holds.
  - REXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Goes to RWB.
  - RWB: reg_write, reg_dst=1, mem_to_reg=0. Goes to FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond, pc_source=01. Goes to FETCH.
  - JUMP: pc_write, pc_source=10. Goes to FETCH.
  - ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to ADDIWB.
  - ADDIWB: reg_write, reg_dst=0, mem_to_reg=0. Goes to FETCH.
- opcode is sampled only in DECODE and MEMADR; changes in other states are ignored.

## Timing
- Reset: state←FETCH asynchronously. While reset_n=0, every output is forced to 0, including mem_read. The first FETCH cycle begins on the first clk edge after reset_n rises.
- Cycles per instruction with mem_ready held at 1: lw 5, sw 4, R 4, addi 4, beq 3, j 3.
- Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle. Strobes stay stable during the stall.
- pc_en is combinational and valid in the same cycle as alu_zero. In BRANCH, pc_en=alu_zero.
- illegal_op is high only during the DECODE cycle with the bad opcode. No state side-effects; the PC has already advanced in FETCH.
- reset_n asserted mid-instruction: outputs drop to 0 immediately and no pending write completes.

## Test plan
- Reset: hold reset_n=0 for 3 cycles with mem_ready=1 → all outputs 0, state=0. After release, first cycle has mem_read=1, ir_write=1, pc_write=1, pc_en=1.
- lw with mem_ready=1 → state sequence 0,1,2,3,4,0. reg_write=1 and mem_to_reg=1 only in state 4.
- sw with mem_ready low for 2 cycles in MEMWR → state 5 held for 3 cycles with mem_write=1 and i_or_d=1, then state 0.
- beq: alu_zero=1 → BRANCH has pc_en=1, pc_source=01. alu_zero=0 → pc_en=0. Both cases take 3 cycles.
- j, R, addi back-to-back → states 0,1,9 / 0,1,6,7 / 0,1,10,11. R has reg_dst=1 in RWB; addi has reg_dst=0 in ADDIWB.
- Opcode 6'b111111 → illegal_op pulses for 1 cycle in DECODE, next state 0. Pulling reset_n low in MEMRD zeroes outputs asynchronously and returns state to 0.
